mem_dump_reader: RTL and testbench

MEM_DUMP_READER -- requirements
Module: mem_dump_reader

---
 rtl/mem_dump_reader.sv | 126 ++++++++++++
 tb/tb_mem_dump_reader.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_dump_reader.sv
// Streams a contiguous (wrapping) range of a synchronous-read memory out through
// a valid/ready port, with at most two words buffered or in flight at any time.
module mem_dump_reader #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] start_adrs,
    input  logic [ADDR_W-1:0] end_adrs,
    output logic              r_enable,
    output logic [ADDR_W-1:0] r_adrs,
    input  logic [DATA_W-1:0] r_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_adrs,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ADRS_ONE = ADDR_W'(1);

    state_t            r_state;
    logic [ADDR_W:0]   r_remain;
    logic              r_rvalid;
    logic [ADDR_W-1:0] r_radrs;
    logic [DATA_W-1:0] r_fdata [2];
    logic [ADDR_W-1:0] r_fadrs [2];
    logic              r_wptr;
    logic              r_rptr;
    logic [1:0]        r_count;

    logic              w_pop;
    logic              w_issue;
    logic              w_last_out;
    logic [2:0]        w_occ;

    assign out_valid = (r_count != 2'd0);
    assign out_data  = r_fdata[r_rptr];
    assign out_adrs  = r_fadrs[r_rptr];
    assign busy      = (r_state != IDLE);
    assign w_pop     = out_valid && out_ready;

    // A word leaving the FIFO this cycle frees its slot for the read issued now;
    // this is what lets a 2-entry FIFO sustain one word per cycle.
    assign w_occ      = {1'b0, r_count} + {2'b00, r_rvalid} - {2'b00, w_pop};
    assign w_issue    = (r_state == RUN) && !abort && (w_occ < 3'd2);
    assign r_enable   = w_issue;
    assign w_last_out = (r_state == DRAIN) && w_pop && (r_count == 2'd1) && !r_rvalid;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= IDLE;
            r_remain   <= '0;
            r_adrs     <= '0;
            r_rvalid   <= 1'b0;
            r_radrs    <= '0;
            r_fdata[0] <= '0;
            r_fdata[1] <= '0;
            r_fadrs[0] <= '0;
            r_fadrs[1] <= '0;
            r_wptr     <= 1'b0;
            r_rptr     <= 1'b0;
            r_count    <= '0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort && r_state != IDLE) begin
                r_state  <= IDLE;
                r_rvalid <= 1'b0;
                r_wptr   <= 1'b0;
                r_rptr   <= 1'b0;
                r_count  <= '0;
            end else begin
                r_rvalid <= w_issue;
                if (w_issue) begin
                    r_radrs  <= r_adrs;
                    r_adrs   <= r_adrs + ADRS_ONE;
                    r_remain <= r_remain - CNT_ONE;
                end
                if (r_rvalid) begin
                    r_fdata[r_wptr] <= r_data;
                    r_fadrs[r_wptr] <= r_radrs;
                    r_wptr          <= ~r_wptr;
                end
                if (w_pop) begin
                    r_rptr <= ~r_rptr;
                end
                r_count <= r_count + {1'b0, r_rvalid} - {1'b0, w_pop};

                case (r_state)
                    IDLE: begin
                        if (start && !abort) begin
                            r_state  <= RUN;
                            r_adrs   <= start_adrs;
                            r_remain <= {1'b0, end_adrs - start_adrs} + CNT_ONE;
                        end
                    end
                    RUN: begin
                        if (w_issue && r_remain == CNT_ONE) begin
                            r_state <= DRAIN;
                        end
                    end
                    DRAIN: begin
                        if (w_last_out) begin
                            r_state <= IDLE;
                            done    <= 1'b1;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_dump_reader.sv
// Randomized bench for mem_dump_reader: a synchronous memory model feeds the DUT and
// every dumped word is checked against a queue built from the address range.
module tb_mem_dump_reader;

    localparam int AW    = 11;
    localparam int DW    = 32;
    localparam int DEPTH = 2048;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          out_ready = 1'b0;
    logic [AW-1:0] start_adrs = '0;
    logic [AW-1:0] end_adrs = '0;
    logic          r_enable;
    logic [AW-1:0] r_adrs;
    logic [DW-1:0] r_data;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_adrs;
    logic          busy;
    logic          done;

    logic [DW-1:0] mem [DEPTH];

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } word_t;

    word_t exp_q[$];
    int    checks   = 0;
    int    failures = 0;

    always #5 clk = ~clk;

    mem_dump_reader #(.ADDR_W(AW), .DATA_W(DW)) u_dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .abort      (abort),
        .start_adrs (start_adrs),
        .end_adrs   (end_adrs),
        .r_enable   (r_enable),
        .r_adrs     (r_adrs),
        .r_data     (r_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_adrs   (out_adrs),
        .busy       (busy),
        .done       (done)
    );

    always_ff @(posedge clk) begin
        if (r_enable) r_data <= mem[r_adrs];
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_r_enable"},  r_enable,  0);
        check_eq({tag, "_r_adrs"},    r_adrs,    0);
        check_eq({tag, "_out_valid"}, out_valid, 0);
        check_eq({tag, "_out_data"},  out_data,  0);
        check_eq({tag, "_out_adrs"},  out_adrs,  0);
        check_eq({tag, "_busy"},      busy,      0);
        check_eq({tag, "_done"},      done,      0);
    endtask

    // One dump from s to e (inclusive, wrapping). abort_at>0 raises abort in that
    // cycle after the accept edge; poke re-requests start while busy.
    task automatic run_dump(input int s, input int e, input int ready_pct,
                            input int abort_at, input bit poke);
        int    n, k, first_valid, busy_cyc, issued, got, first_x, last_x;
        bit    hold, fin;
        logic [DW-1:0] hd;
        logic [AW-1:0] ha;
        word_t w;

        n = ((e - s) % DEPTH + DEPTH) % DEPTH + 1;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            w.a = AW'((s + i) % DEPTH);
            w.d = mem[(s + i) % DEPTH];
            exp_q.push_back(w);
        end

        @(posedge clk); #1;
        start      = 1'b1;
        abort      = 1'b0;
        start_adrs = AW'(s);
        end_adrs   = AW'(e);
        out_ready  = ($urandom_range(99) < ready_pct);
        @(posedge clk); #1;

        first_valid = -1; busy_cyc = 0; issued = 0; got = 0;
        first_x = -1; last_x = -1; hold = 0; fin = 0; hd = '0; ha = '0;
        for (k = 1; k <= 400 && !fin; k++) begin
            if (poke && k == 2) begin
                start      = 1'b1;
                start_adrs = AW'(s + 7);
                end_adrs   = AW'(s + 9);
            end else begin
                start = 1'b0;
            end
            abort     = (k == abort_at);
            out_ready = (k == abort_at) ? 1'b0 : ($urandom_range(99) < ready_pct);
            @(negedge clk);
            if (abort_at > 0 && k == abort_at + 1) begin
                check_eq("abort_out_valid", out_valid, 0);
                check_eq("abort_busy", busy, 0);
                check_eq("abort_done", done, 0);
                fin = 1;
            end else if (!busy) begin
                check_eq("done_pulse", done, 1);
                check_eq("words_left", exp_q.size(), 0);
                if (abort_at == 0) begin
                    check_eq("first_latency", first_valid, 3);
                    if (ready_pct >= 100) begin
                        check_eq("busy_cycles", busy_cyc, n + 2);
                        check_eq("back_to_back", last_x - first_x, n - 1);
                    end
                end
                fin = 1;
            end else begin
                busy_cyc++;
                check_eq("done_while_busy", done, 0);
                if (hold) begin
                    check_eq("hold_valid", out_valid, 1);
                    check_eq("hold_data", out_data, hd);
                    check_eq("hold_adrs", out_adrs, ha);
                end
                if (out_valid && first_valid < 0) first_valid = k;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check_eq("extra_word", out_adrs, 0 - 1);
                    end else begin
                        w = exp_q.pop_front();
                        check_eq("word_adrs", out_adrs, w.a);
                        check_eq("word_data", out_data, w.d);
                    end
                    got++;
                    if (first_x < 0) first_x = k;
                    last_x = k;
                end
                if (r_enable) begin
                    issued++;
                    check_eq("outstanding_le2", (issued - got) <= 2, 1);
                end
                hold = out_valid && !out_ready;
                hd   = out_data;
                ha   = out_adrs;
            end
            @(posedge clk); #1;
        end
        if (!fin) check_eq("timeout", 0, 1);
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        check_eq("done_one_cycle", done, 0);
        check_eq("idle_after", busy, 0);
    endtask

    initial begin
        int s, len, pct;

        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        mem[30] = 32'h0000_000F;
        mem[31] = 32'hF000_0000;

        #1;
        check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;

        run_dump(30, 31, 100, 0, 0);
        run_dump(5, 5, 100, 0, 0);
        run_dump(2046, 1, 100, 0, 0);
        run_dump(1, 10, 50, 0, 0);
        run_dump(0, 15, 100, 3, 0);
        run_dump(0, 0, 100, 0, 0);

        @(posedge clk); #1;
        start = 1'b1; abort = 1'b1; start_adrs = AW'(3); end_adrs = AW'(9);
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        check_eq("start_abort_busy", busy, 0);
        check_eq("start_abort_r_enable", r_enable, 0);

        @(posedge clk); #1;
        start = 1'b1; start_adrs = AW'(100); end_adrs = AW'(120); out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        check_eq("pre_reset_valid", out_valid, 1);
        #1;
        resetn = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(posedge clk); #2;
        check_all_zero("held_reset");
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check_eq("post_reset_busy", busy, 0);
        check_eq("post_reset_done", done, 0);
        run_dump(200, 205, 100, 0, 0);

        repeat (12) begin
            s   = $urandom_range(DEPTH - 1);
            len = $urandom_range(20);
            pct = ($urandom_range(3) == 0) ? 100 : $urandom_range(30, 90);
            run_dump(s, (s + len) % DEPTH, pct, 0, $urandom_range(1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
